// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced N-to-2**N decoder.
package decoder_pkg;

    localparam int MAX_N = 6;
    localparam int MAX_W = 1 << MAX_N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Callers truncate to their own 2**N width.
    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] a);
        onehot = {{(MAX_W-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts SCAN cycles spent on one address; tick marks the last one.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DWELL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2**N one-hot decoder with DIRECT and dwell-timed SCAN modes.
// Optional wrap pulse output enabled by DECODER_WRAP_FLAG_EN.
module decoder_nx2n_seq
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic             mode,
    input  logic [N-1:0]     x,
    input  logic             load,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]     addr_q,
    output logic             valid
`ifdef DECODER_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    localparam int W = 1 << N;

    state_e         state_q;
    state_e         state_d;
    logic [N-1:0]   addr_d;
    logic [W-1:0]   y_d;
    logic           stay_scan;
    logic           cnt_clr;
    logic           cnt_en;
    logic           tick;

    always_comb begin
        state_d = IDLE;
        unique case (1'b1)
            !e:                        state_d = IDLE;
            e && mode == MODE_DIRECT:  state_d = DIRECT;
            e && mode == MODE_SCAN:    state_d = SCAN;
            default:                   state_d = IDLE;
        endcase
    end

    assign stay_scan = (state_q == SCAN) && (state_d == SCAN);

    // Entry to SCAN and load both restart the dwell; load beats expiry.
    always_comb begin
        addr_d  = addr_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        unique case (state_d)
            DIRECT: addr_d = x;
            SCAN: begin
                if (load) begin
                    addr_d = x;
                end else if (stay_scan) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                    if (tick) begin
                        addr_d = addr_q + N'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign y_d = W'(onehot(MAX_N'(addr_d)));

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            y       <= '0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            y       <= (state_d == IDLE) ? '0 : y_d;
            valid   <= (state_d != IDLE);
        end
    end

`ifdef DECODER_WRAP_FLAG_EN
    logic wrap_d;

    assign wrap_d = stay_scan && !load && tick && (&addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_d;
        end
    end
`else
    // No wrap flag in this build.
`endif

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Self-checking bench: two N=3 instances (DWELL=3 and DWELL=1) against a
// behavioural model, with directed scenarios followed by random stimulus.
module tb_decoder_nx2n_seq;

    localparam int N = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         e     = 1'b0;
    logic         mode  = 1'b0;
    logic         load  = 1'b0;
    logic [N-1:0] x     = '0;

    logic [7:0]   y_a, y_b;
    logic [N-1:0] addr_a, addr_b;
    logic         valid_a, valid_b;
`ifdef DECODER_WRAP_FLAG_EN
    logic         wrap_a, wrap_b;
`endif

    int errors = 0;
    int checks = 0;

    int m_st[2];
    int m_addr[2];
    int m_cnt[2];
    int m_wrap[2];

    always #5 clk = ~clk;

    decoder_nx2n_seq #(.N(N), .DWELL(3)) u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .mode   (mode),
        .x      (x),
        .load   (load),
        .y      (y_a),
        .addr_q (addr_a),
        .valid  (valid_a)
`ifdef DECODER_WRAP_FLAG_EN
        ,
        .wrap   (wrap_a)
`endif
    );

    decoder_nx2n_seq #(.N(N), .DWELL(1)) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .mode   (mode),
        .x      (x),
        .load   (load),
        .y      (y_b),
        .addr_q (addr_b),
        .valid  (valid_b)
`ifdef DECODER_WRAP_FLAG_EN
        ,
        .wrap   (wrap_b)
`endif
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dw(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = 0;
            m_addr[k] = 0;
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
        end
    endfunction

    // State codes: 0 idle, 1 direct, 2 scan. m_cnt = cycles already spent
    // on the current scan address beyond the first.
    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            if (!e) begin
                m_st[k]  = 0;
                m_cnt[k] = 0;
            end else if (mode == 1'b0) begin
                m_st[k]   = 1;
                m_addr[k] = int'(x);
                m_cnt[k]  = 0;
            end else if (m_st[k] != 2 || load) begin
                if (load) m_addr[k] = int'(x);
                m_st[k]  = 2;
                m_cnt[k] = 0;
            end else if (m_cnt[k] + 1 == dw(k)) begin
                m_wrap[k] = (m_addr[k] == 7) ? 1 : 0;
                m_addr[k] = (m_addr[k] + 1) % 8;
                m_cnt[k]  = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endfunction

    function automatic logic [7:0] m_y(int k);
        int v;
        v = (m_st[k] == 0) ? 0 : (2 ** m_addr[k]);
        return 8'(v);
    endfunction

    task automatic check_all(string tag);
        chk({tag, "/a.y"}, y_a, m_y(0));
        chk({tag, "/a.addr"}, addr_a, m_addr[0]);
        chk({tag, "/a.valid"}, valid_a, m_st[0] != 0);
        chk({tag, "/a.onehot"}, $countones(y_a) <= 1, 1);
        chk({tag, "/b.y"}, y_b, m_y(1));
        chk({tag, "/b.addr"}, addr_b, m_addr[1]);
        chk({tag, "/b.valid"}, valid_b, m_st[1] != 0);
        chk({tag, "/b.onehot"}, $countones(y_b) <= 1, 1);
`ifdef DECODER_WRAP_FLAG_EN
        chk({tag, "/a.wrap"}, wrap_a, m_wrap[0]);
        chk({tag, "/b.wrap"}, wrap_b, m_wrap[1]);
`endif
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        m_step();
        #1;
        check_all(tag);
    endtask

    // Reset is pulsed between edges and checked before any clock arrives.
    task automatic async_reset(string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        chk({tag, "/a.y0"}, y_a, 8'h00);
        chk({tag, "/a.v0"}, valid_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        m_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle_after_reset");
        tick("idle_after_reset");

        e    = 1'b1;
        mode = 1'b0;
        for (int v = 0; v < 8; v++) begin
            x = 3'(v);
            repeat (3) tick("direct");
        end
        e = 1'b0;
        tick("disable");

        e    = 1'b1;
        mode = 1'b1;
        load = 1'b1;
        x    = 3'd6;
        tick("scan_load6");
        load = 1'b0;
        repeat (16) tick("scan_run");

        load = 1'b1;
        x    = 3'd2;
        tick("scan_load2");
        load = 1'b0;
        tick("scan_dw1");
        tick("scan_dw2");
        load = 1'b1;
        x    = 3'd0;
        tick("load_at_expiry");
        chk("load_at_expiry/a.y", y_a, 8'h01);
        load = 1'b0;
        repeat (4) tick("after_load0");

        load = 1'b1;
        x    = 3'd5;
        tick("scan_load5");
        load = 1'b0;
        tick("scan_at5");
        async_reset("mid_scan_reset");
        tick("resume_scan");
        chk("resume_scan/a.y", y_a, 8'h01);

        mode = 1'b0;
        x    = 3'd3;
        tick("direct3");
        mode = 1'b1;
        x    = 3'd0;
        repeat (6) tick("direct_to_scan");

        repeat (600) begin
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            load = ($urandom_range(0, 7) == 0);
            x    = 3'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand_reset");
            end else begin
                tick("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
